// File: rtl/norz_bus_pkg.sv
// norz_bus_pkg: shared types and constants for the Z80-style bus cycle unit.
//   state_e : T-state sequencer states (IDLE, T1, T2, TW, T3, T4)
//   kind_e  : machine-cycle kind latched when a request is accepted
//   helpers : classify a cycle kind (I/O, write, read-like)
package norz_bus_pkg;

    localparam int unsigned AddrWDefault = 16;
    localparam int unsigned DataWDefault = 8;
    localparam int unsigned RefreshW     = 7;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        T4
    } state_e;

    typedef enum logic [2:0] {
        FETCH,
        MREAD,
        MWRITE,
        IOREAD,
        IOWRITE
    } kind_e;

    function automatic logic kind_is_io(input kind_e k);
        return (k == IOREAD) || (k == IOWRITE);
    endfunction

    function automatic logic kind_is_write(input kind_e k);
        return (k == MWRITE) || (k == IOWRITE);
    endfunction

    // Cycles that drive RD_n and bring data back from the bus.
    function automatic logic kind_is_read(input kind_e k);
        return (k == FETCH) || (k == MREAD) || (k == IOREAD);
    endfunction

endpackage

// File: rtl/norz_wait_counter.sv
// norz_wait_counter: counts the automatic wait states of an I/O cycle and tells
// the sequencer when the external WAIT_n line may be sampled.
//   clk_i       : clock, one T-state per rising edge
//   rst_i       : synchronous active-high reset
//   clear_i     : restart the count (asserted in T1)
//   tw_i        : sequencer is in a TW state this cycle
//   io_i        : current cycle is an I/O cycle
//   sample_ok_o : WAIT_n is to be honoured at the end of this T-state
module norz_wait_counter #(
    parameter int unsigned AUTO_WAITS = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tw_i,
    input  logic io_i,
    output logic sample_ok_o
);

    localparam logic [2:0] AutoW = 3'(AUTO_WAITS);

    logic [2:0] count_q, count_d;
    logic [2:0] done_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tw_i && (count_q < AutoW)) begin
            count_d = count_q + 3'd1;
        end
    end

    // TW states completed by the end of this T-state, the current one included.
    always_comb begin
        done_cnt    = count_q + {2'b00, tw_i};
        sample_ok_o = !io_i || (done_cnt >= AutoW);
    end

endmodule

// File: rtl/norz_bus_cycle_unit.sv
// norz_bus_cycle_unit: runs the T-state sequence of opcode-fetch, memory and
// I/O machine cycles on a Z80-style bus, one T-state per CLK edge.
//   CLK, RESET            : clock and synchronous active-high reset
//   Req_Fetch/Read/Write  : cycle requests (priority Fetch > Write > Read)
//   Req_IO                : Read/Write is an I/O cycle
//   Address, Data_Out     : cycle address and write data, latched on acceptance
//   Bus_Data_In, WAIT_n   : external data bus and wait line
//   Bus_A, Bus_D, Bus_D_OE: address bus, write data and its drive enable
//   MREQ_n..RFSH_n        : active-low bus strobes
//   Read_Data, Read_Valid : captured read/fetch data and its one-cycle strobe
//   Cycle_Done, Busy      : final-T-state pulse, cycle in flight
// Optional build macro NORZ_REFRESH_EN adds the T3/T4 refresh tail to fetches
// with a 7-bit refresh counter R; without it RFSH_n is tied high.
module norz_bus_cycle_unit
    import norz_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = AddrWDefault,
    parameter int unsigned DATA_W       = DataWDefault,
    parameter int unsigned IO_AUTO_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Req_Fetch,
    input  logic              Req_Read,
    input  logic              Req_Write,
    input  logic              Req_IO,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_Out,
    input  logic [DATA_W-1:0] Bus_Data_In,
    input  logic              WAIT_n,
    output logic [ADDR_W-1:0] Bus_A,
    output logic [DATA_W-1:0] Bus_D,
    output logic              Bus_D_OE,
    output logic              MREQ_n,
    output logic              IORQ_n,
    output logic              RD_n,
    output logic              WR_n,
    output logic              M1_n,
    output logic              RFSH_n,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Read_Valid,
    output logic              Cycle_Done,
    output logic              Busy
);

`ifdef NORZ_REFRESH_EN
    localparam logic RefreshOn = 1'b1;
    logic [RefreshW-1:0] r_q, r_d;
`else
    localparam logic RefreshOn = 1'b0;
`endif

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic is_io, is_write, is_read, is_fetch;
    logic cycle_done, accept, sample_ok, in_access, late;

    assign is_io    = kind_is_io(kind_q);
    assign is_write = kind_is_write(kind_q);
    assign is_read  = kind_is_read(kind_q);
    assign is_fetch = (kind_q == FETCH);

    norz_wait_counter #(
        .AUTO_WAITS (IO_AUTO_WAIT)
    ) u_wait_counter (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .clear_i     (state_q == T1),
        .tw_i        (state_q == TW),
        .io_i        (is_io),
        .sample_ok_o (sample_ok)
    );

    // Requests are taken in IDLE or in the final T-state, so cycles can abut.
    always_comb begin
        cycle_done = (state_q == T4) || ((state_q == T3) && !(RefreshOn && is_fetch));
        accept     = ((state_q == IDLE) || cycle_done) && (Req_Fetch || Req_Read || Req_Write);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            kind_q   <= MREAD;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef NORZ_REFRESH_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            T1:      state_d = T2;
            T2, TW:  state_d = (sample_ok && WAIT_n) ? T3 : TW;
            T3:      state_d = (RefreshOn && is_fetch) ? T4 : IDLE;
            T4:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = T1;
            addr_d  = Address;
            wdata_d = Data_Out;
            if (Req_Fetch) begin
                kind_d = FETCH;
            end else if (Req_Write) begin
                kind_d = Req_IO ? IOWRITE : MWRITE;
            end else begin
                kind_d = Req_IO ? IOREAD : MREAD;
            end
        end
    end

    // Read capture: reads on the edge leaving T3, fetches on the edge leaving
    // the last T2/TW so the opcode is in hand before the refresh tail.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if ((state_q == T3) && ((kind_q == MREAD) || (kind_q == IOREAD))) begin
            rdata_d  = Bus_Data_In;
            rvalid_d = 1'b1;
        end
        if (is_fetch && ((state_q == T2) || (state_q == TW)) && (state_d == T3)) begin
            rdata_d  = Bus_Data_In;
            rvalid_d = 1'b1;
        end
`ifdef NORZ_REFRESH_EN
        r_d = r_q;
        if (state_q == T4) begin
            r_d = r_q + 7'd1;
        end
`endif
    end

    // Output logic
    always_comb begin
        Bus_A      = '0;
        Bus_D      = '0;
        Bus_D_OE   = 1'b0;
        MREQ_n     = 1'b1;
        IORQ_n     = 1'b1;
        RD_n       = 1'b1;
        WR_n       = 1'b1;
        M1_n       = 1'b1;
        RFSH_n     = 1'b1;
        Busy       = (state_q != IDLE);
        Cycle_Done = cycle_done;
        Read_Data  = rdata_q;
        Read_Valid = rvalid_q;

        // A fetch's access phase ends at its last T2/TW; other kinds include T3.
        in_access = (state_q == T1) || (state_q == T2) || (state_q == TW) ||
                    ((state_q == T3) && !is_fetch);
        late      = (state_q != T1);

        if (state_q != IDLE) begin
            Bus_A = addr_q;
        end
        if (in_access) begin
            MREQ_n = is_io;
            IORQ_n = !(is_io && late);
            RD_n   = !(is_read && (!is_io || late));
            WR_n   = !(is_write && late);
            M1_n   = !is_fetch;
            if (is_write) begin
                Bus_D    = wdata_q;
                Bus_D_OE = 1'b1;
            end
        end
`ifdef NORZ_REFRESH_EN
        if (is_fetch && ((state_q == T3) || (state_q == T4))) begin
            Bus_A  = {{(ADDR_W - RefreshW){1'b0}}, r_q};
            RFSH_n = 1'b0;
            MREQ_n = (state_q != T3);
        end
`endif
    end

endmodule

// File: tb/tb_norz_bus_cycle_unit.sv
module tb_norz_bus_cycle_unit;

    localparam int AUTO  = 1;
    localparam int NSLOT = 4096;
`ifdef NORZ_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Req_Fetch, Req_Read, Req_Write, Req_IO;
    logic [15:0] Address;
    logic [7:0]  Data_Out, Bus_Data_In;
    logic        WAIT_n;
    logic [15:0] Bus_A;
    logic [7:0]  Bus_D, Read_Data;
    logic        Bus_D_OE, MREQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n;
    logic        Read_Valid, Cycle_Done, Busy;

    norz_bus_cycle_unit #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .IO_AUTO_WAIT (AUTO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Req_Fetch   (Req_Fetch),
        .Req_Read    (Req_Read),
        .Req_Write   (Req_Write),
        .Req_IO      (Req_IO),
        .Address     (Address),
        .Data_Out    (Data_Out),
        .Bus_Data_In (Bus_Data_In),
        .WAIT_n      (WAIT_n),
        .Bus_A       (Bus_A),
        .Bus_D       (Bus_D),
        .Bus_D_OE    (Bus_D_OE),
        .MREQ_n      (MREQ_n),
        .IORQ_n      (IORQ_n),
        .RD_n        (RD_n),
        .WR_n        (WR_n),
        .M1_n        (M1_n),
        .RFSH_n      (RFSH_n),
        .Read_Data   (Read_Data),
        .Read_Valid  (Read_Valid),
        .Cycle_Done  (Cycle_Done),
        .Busy        (Busy)
    );

    always #5 CLK = ~CLK;

    // Slot k = the clock period following the k-th rising edge.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        oe, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, done, busy;
    } bus_t;

    bus_t       exp_bus [NSLOT];
    bit         has_bus [NSLOT];
    bit         exp_rv  [NSLOT];
    logic [7:0] exp_rd  [NSLOT];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int r_m      = 0;

    function automatic bus_t idle_bus();
        bus_t e;
        e = '0;
        e.mreq_n = 1'b1; e.iorq_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
        e.m1_n   = 1'b1; e.rfsh_n = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the bus picture of every T-state of one accepted cycle, from the
    // protocol rules (kind, auto waits, sampled waits), written into slot tables.
    task automatic model_fill(input int c, input bit f, input bit w, input bit io,
                              input logic [15:0] addr, input logic [7:0] data,
                              input int waits, input logic [7:0] bin,
                              output int len, output int aw);
        int   k, last_acc;
        bit   fetch, is_mem, is_rd, is_wr, rf;
        bus_t e;
        if (f)      k = 0;
        else if (w) k = io ? 4 : 2;
        else        k = io ? 3 : 1;
        fetch  = (k == 0);
        is_mem = (k <= 2);
        is_rd  = (k == 0) || (k == 1) || (k == 3);
        is_wr  = (k == 2) || (k == 4);
        aw     = (k >= 3) ? AUTO : 0;
        rf     = REFRESH && fetch;
        len    = 3 + aw + waits + (rf ? 1 : 0);
        last_acc = fetch ? 2 + aw + waits : 3 + aw + waits;
        for (int i = 1; i <= len; i++) begin
            e = idle_bus();
            e.busy = 1'b1;
            e.a    = addr;
            e.done = (i == len);
            if (i <= last_acc) begin
                if (is_mem) e.mreq_n = 1'b0;
                if (is_rd && (is_mem || i >= 2)) e.rd_n = 1'b0;
                if (is_wr && i >= 2) e.wr_n = 1'b0;
                if (!is_mem && i >= 2) e.iorq_n = 1'b0;
                if (fetch) e.m1_n = 1'b0;
                if (is_wr) begin e.oe = 1'b1; e.d = data; end
            end else if (rf) begin
                e.a      = 16'(r_m);
                e.rfsh_n = 1'b0;
                if (i == len - 1) e.mreq_n = 1'b0;
            end
            exp_bus[c+i] = e;
            has_bus[c+i] = 1'b1;
        end
        if (fetch) begin
            exp_rv[c+3+waits] = 1'b1;
            exp_rd[c+3+waits] = bin;
        end else if (is_rd) begin
            exp_rv[c+len+1] = 1'b1;
            exp_rd[c+len+1] = bin;
        end
        if (rf) r_m = (r_m + 1) % 128;
    endtask

    // Called at a falling edge inside an acceptance window; returns at the
    // falling edge of the cycle's final T-state (or one slot after an abort).
    task automatic xact(input bit f, input bit r, input bit w, input bit io,
                        input logic [15:0] addr, input logic [7:0] data,
                        input int waits, input logic [7:0] bin, input int abort_at,
                        output int busy_cnt, output logic [15:0] a_pen);
        int c, len, aw;
        c = cyc;
        model_fill(c, f, w, io, addr, data, waits, bin, len, aw);
        Req_Fetch = f; Req_Read = r; Req_Write = w; Req_IO = io;
        Address = addr; Data_Out = data;
        busy_cnt = 0;
        a_pen    = '0;
        for (int i = 1; i <= len; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                Req_Fetch = 0; Req_Read = 0; Req_Write = 0; Req_IO = 0;
                Bus_Data_In = bin;
            end
            WAIT_n = (waits > 0 && i <= 1 + aw + waits) ? 1'b0 : 1'b1;
            if (Busy) busy_cnt++;
            if (i == len - 1) a_pen = Bus_A;
            if (abort_at == i) begin
                RESET  = 1'b1;
                WAIT_n = 1'b1;
                for (int s = c + i + 1; s <= c + len + 2; s++) begin
                    has_bus[s] = 1'b0;
                    exp_rv[s]  = 1'b0;
                end
                r_m = 0;
                @(negedge CLK);
                RESET = 1'b0;
                break;
            end
        end
    endtask

    // Compare process: every cycle, the DUT bus against the model tables.
    always @(negedge CLK) begin
        bus_t act, e;
        if (chk_en && cyc < NSLOT) begin
            act = {Bus_A, Bus_D, Bus_D_OE, MREQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n,
                   Cycle_Done, Busy};
            e = has_bus[cyc] ? exp_bus[cyc] : idle_bus();
            check($sformatf("bus_slot%0d", cyc), 64'(act), 64'(e));
            check($sformatf("read_valid_slot%0d", cyc), 64'(Read_Valid), 64'(exp_rv[cyc]));
            if (exp_rv[cyc]) check($sformatf("read_data_slot%0d", cyc), 64'(Read_Data),
                                   64'(exp_rd[cyc]));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int          bc;
        logic [15:0] ap;
        RESET = 1'b1;
        Req_Fetch = 0; Req_Read = 0; Req_Write = 0; Req_IO = 0;
        Address = '0; Data_Out = '0; Bus_Data_In = '0; WAIT_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_strobes", 64'({MREQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n}), 64'h3f);
        check("reset_read_data", 64'(Read_Data), 64'd0);
        check("reset_bus_a", 64'(Bus_A), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // 1: memory read, no waits
        xact(0, 1, 0, 0, 16'h1234, 8'h00, 0, 8'hA5, 0, bc, ap);
        check("t1_busy_cycles", 64'(bc), 64'd3);
        @(negedge CLK);
        check("t1_read_valid", 64'(Read_Valid), 64'd1);
        check("t1_read_data", 64'(Read_Data), 64'hA5);

        // 2: memory write with two sampled waits
        xact(0, 0, 1, 0, 16'h8000, 8'h3C, 2, 8'h00, 0, bc, ap);
        check("t2_busy_cycles", 64'(bc), 64'd5);
        @(negedge CLK);

        // 3: I/O read, one forced wait
        xact(0, 1, 0, 1, 16'h00FE, 8'h00, 0, 8'h5A, 0, bc, ap);
        check("t3_busy_cycles", 64'(bc), 64'd4);
        @(negedge CLK);
        check("t3_read_data", 64'(Read_Data), 64'h5A);

        // 3b: I/O write with one sampled wait after the forced one
        xact(0, 0, 1, 1, 16'h0042, 8'hC3, 1, 8'h00, 0, bc, ap);
        check("t3b_busy_cycles", 64'(bc), 64'd5);
        @(negedge CLK);

        // 4: fetch beats read, then a read accepted in the Cycle_Done cycle
        xact(1, 1, 0, 0, 16'h0100, 8'h00, 1, 8'h77, 0, bc, ap);
        check("t4_fetch_busy", 64'(bc), REFRESH ? 64'd5 : 64'd4);
        xact(0, 1, 0, 0, 16'h0200, 8'h00, 0, 8'h99, 0, bc, ap);
        check("t4_b2b_busy", 64'(bc), 64'd3);
        @(negedge CLK);
        check("t4_read_data", 64'(Read_Data), 64'h99);

        // 6: reset in TW of a read aborts it
        xact(0, 1, 0, 0, 16'h4444, 8'h00, 3, 8'hEE, 3, bc, ap);
        check("t6_busy", 64'(Busy), 64'd0);
        check("t6_strobes", 64'({MREQ_n, RD_n, WR_n, M1_n}), 64'hf);
        check("t6_read_data", 64'(Read_Data), 64'd0);
        check("t6_read_valid", 64'(Read_Valid), 64'd0);
        @(negedge CLK);
        check("t6_no_late_valid", 64'(Read_Valid), 64'd0);

        // 5: fetches (refresh address sequence and wrap when enabled)
        xact(1, 0, 0, 0, 16'h0ABC, 8'h00, 0, 8'h11, 0, bc, ap);
        check("t5_fetch0_a", 64'(ap), REFRESH ? 64'h0000 : 64'h0ABC);
        check("t5_fetch0_busy", 64'(bc), REFRESH ? 64'd4 : 64'd3);
        xact(1, 0, 0, 0, 16'h0ABD, 8'h00, 0, 8'h22, 0, bc, ap);
        check("t5_fetch1_a", 64'(ap), REFRESH ? 64'h0001 : 64'h0ABD);
        if (REFRESH) begin
            for (int n = 2; n < 128; n++) begin
                xact(1, 0, 0, 0, 16'(16'h1000 + n), 8'h00, 0, 8'(n), 0, bc, ap);
            end
            xact(1, 0, 0, 0, 16'h2000, 8'h00, 0, 8'h33, 0, bc, ap);
            check("t5_wrap_a", 64'(ap), 64'h0000);
        end

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/norz_bus_cycle_unit.md
Name: norz_bus_cycle_unit

Overview:
Bus-side counterpart of the instruction decoders. Decoder XPT steps request opcode-fetch, memory and I/O read/write machine cycles. This block runs the T-state sequence for each request on the external Z80-style bus (MREQ/IORQ/RD/WR/M1/RFSH, WAIT). It returns read data for the Dt register and holds XPT while a cycle is in flight. One clock edge equals one T-state; it sits between the decode/XPT logic and the pin interface.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
IO_AUTO_WAIT, 1, wait states always inserted after T2 of I/O cycles (0..3)

Ports:
CLK  in  1  clock; one T-state per rising edge
RESET  in  1  synchronous, active-high reset
Req_Fetch  in  1  start M1 opcode-fetch cycle
Req_Read  in  1  start read cycle
Req_Write  in  1  start write cycle
Req_IO  in  1  qualifies Read/Write as I/O (ignored with Fetch)
Address  in  ADDR_W  cycle address, sampled at acceptance
Data_Out  in  DATA_W  write data, sampled at acceptance
Bus_Data_In  in  DATA_W  external data bus input
WAIT_n  in  1  external wait, active low
Bus_A  out  ADDR_W  address bus
Bus_D  out  DATA_W  write data to bus
Bus_D_OE  out  1  Bus_D drive enable
MREQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n  out  1 each  bus strobes, active low
Read_Data  out  DATA_W  captured read/fetch data
Read_Valid  out  1  one-cycle pulse, Read_Data updated
Cycle_Done  out  1  one-cycle pulse in final T-state
Busy  out  1  high while state != IDLE; XPT must not advance

Behaviour:
- Reset behaviour: on RESET, go to IDLE. All *_n go high. Bus_A, Bus_D, Read_Data and R go to 0. Bus_D_OE, Read_Valid, Cycle_Done and Busy go to 0. RESET mid-cycle aborts the cycle: no Read_Valid, no Cycle_Done.
- States: IDLE, T1, T2, TW, T3, T4 (T4 is used only with the refresh feature).
- Request acceptance:
  - Requests are sampled only in IDLE or in a cycle where Cycle_Done=1, which gives back-to-back cycles with no gap.
  - Otherwise requests are ignored; a bench assertion flags them.
  - Priority: Fetch > Write > Read. Acceptance moves the state to T1 and registers Address, Data_Out, kind and Req_IO.
- Memory read/write:
  - T1: Bus_A=address. MREQ_n=0. Read: RD_n=0. Write: Bus_D=data, Bus_D_OE=1.
  - T2: write sets WR_n=0.
  - WAIT_n is sampled at the end of T2 and of each TW: 0 gives TW, 1 gives T3.
  - T3: Cycle_Done=1. For a read, Bus_Data_In is captured on the edge leaving T3 and Read_Valid pulses in the next cycle. Strobes return high on the edge leaving T3.
  - Bus_D_OE drops with WR_n.
- I/O:
  - MREQ_n stays 1. IORQ_n=0 and RD_n/WR_n are asserted from T2.
  - IO_AUTO_WAIT TW states are inserted unconditionally before WAIT_n is first sampled.
- Fetch:
  - T1: M1_n=0, MREQ_n=0, RD_n=0. Wait handling is the same as for reads.
  - Data is captured on the edge leaving the last T2/TW.
  - Without the refresh feature, T3 is the final state: Cycle_Done=1, strobes high.
- Latency:
  - Read, write and fetch take 3+W cycles; I/O takes 3+IO_AUTO_WAIT+W cycles (W = sampled waits).
  - With the refresh feature, fetch takes 4+W cycles.
- Busy: registered, =1 from T1 through the final state.
- WAIT_n held low indefinitely: the block stays in TW with no timeout.

Optional Feature:
NORZ_REFRESH_EN
- Defined: fetch continues with T3 and T4. In T3 and T4: M1_n=1, RD_n=1, RFSH_n=0, Bus_A = {zeros, R[6:0]}. MREQ_n=0 in T3 only. Cycle_Done=1 in T4.
  - R is a 7-bit counter; it increments (mod 128) on the edge leaving T4.
  - RESET clears R.
- Undefined: RFSH_n is tied high, there is no R counter, and fetch ends at T3.

Decomposition:
- Package norz_bus_pkg holds:
  - the state enum (IDLE, T1, T2, TW, T3, T4);
  - the cycle-kind enum (FETCH, MREAD, MWRITE, IOREAD, IOWRITE);
  - default width constants.
- One sub-module, norz_wait_counter, counts auto-wait TW states for I/O and signals when WAIT_n may be sampled.

Test Plan:
1. Req_Read, Address=0x1234, WAIT_n=1, Bus_Data_In=0xA5 -> MREQ_n/RD_n low for 3 cycles, Bus_A=0x1234. Read_Data=0xA5 with Read_Valid one cycle after T3. Cycle_Done in T3.
2. Req_Write, Address=0x8000, Data_Out=0x3C, WAIT_n low for 2 samples -> T1,T2,TW,TW,T3. WR_n low T2..T3, Bus_D=0x3C with OE, Busy=1 for 5 cycles.
3. Req_Read+Req_IO, IO_AUTO_WAIT=1 -> MREQ_n stays 1. IORQ_n/RD_n low from T2, one forced TW even with WAIT_n=1, 4 cycles total.
4. Req_Fetch and Req_Read in the same cycle -> fetch wins with M1_n low. The next Req_Read is asserted in the Cycle_Done cycle and is accepted with T1 the following cycle.
5. NORZ_REFRESH_EN: two fetches -> Bus_A[6:0]=0x00 then 0x01 in T3/T4. RFSH_n low T3..T4. After 128 fetches, R wraps to 0.
6. RESET asserted in TW of a read -> next cycle IDLE, all strobes high, Read_Valid never pulses, Busy=0.
